nf_10g_rx_port_stats: RTL and testbench

Registered AXI4-Stream stage placed directly downstream of the 10G interface's 256-bit pipeline output, on the core clock domain and ahead of the input arbiter. Passes every frame through unchanged with one cycle of latency and a fully registered `s_axis_tready`. Accumulates per-port frame, byte, runt, giant, length-mismatch and link-drop counters. The counters are exposed through a snapshot-and-clear interface for the register block.

---
 rtl/nf_10g_rx_port_stats.sv | 199 +++++++++++++++++++
 tb/tb_nf_10g_rx_port_stats.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_10g_rx_port_stats.sv
// Registered AXIS pass-through (1-cycle latency, 2-entry skid, registered tready) with per-port
// frame/byte/runt/giant/length-error/link-drop counters and a snapshot-and-clear stats interface.
module nf_10g_rx_port_stats #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_BYTE_CNT_WIDTH   = 48,
  parameter int C_MIN_FRAME        = 60,
  parameter int C_MAX_FRAME        = 1514
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              link_up,
  input  logic                              stats_snapshot,
  output logic [31:0]                       stat_pkts,
  output logic [C_BYTE_CNT_WIDTH-1:0]       stat_bytes,
  output logic [31:0]                       stat_runts,
  output logic [31:0]                       stat_giants,
  output logic [31:0]                       stat_len_err,
  output logic [31:0]                       stat_link_drops,
  output logic                              stat_valid
);
  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = $clog2(KEEP_W + 1);
  localparam logic [15:0] MIN_LEN = 16'(C_MIN_FRAME);
  localparam logic [15:0] MAX_LEN = 16'(C_MAX_FRAME);

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]  data;
    logic [KEEP_W-1:0]             keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] user;
    logic                          last;
  } beat_t;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  beat_t in_beat, main_q, skid_q;
  logic  main_vld, skid_vld, in_rdy;
  logic  accept, load_main;

  assign in_beat   = '{data: s_axis_tdata, keep: s_axis_tkeep, user: s_axis_tuser, last: s_axis_tlast};
  assign accept    = s_axis_tvalid && in_rdy;
  assign load_main = !main_vld || m_axis_tready;

  // in_rdy is the registered "skid empty next cycle" so m_axis_tready never reaches s_axis_tready combinationally
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      in_rdy   <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      if (load_main) begin
        if (skid_vld) begin
          main_q   <= skid_q;
          main_vld <= 1'b1;
          skid_vld <= 1'b0;
        end else begin
          main_vld <= accept;
          if (accept) main_q <= in_beat;
        end
      end else if (accept) begin
        skid_q   <= in_beat;
        skid_vld <= 1'b1;
      end
      in_rdy <= load_main || !(skid_vld || accept);
    end
  end

  assign s_axis_tready = in_rdy;
  assign m_axis_tvalid = main_vld;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tkeep  = main_q.keep;
  assign m_axis_tuser  = main_q.user;
  assign m_axis_tlast  = main_q.last;

  logic [BEAT_W-1:0] beat_bytes;
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) beat_bytes = beat_bytes + BEAT_W'(s_axis_tkeep[i]);
  end

  state_t      state;
  logic [15:0] frame_len, exp_len;
  logic [16:0] len_sum;
  logic [15:0] len_acc, end_len, end_exp;
  logic        frame_end;

  assign len_sum   = {1'b0, frame_len} + 17'(beat_bytes);
  assign len_acc   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  assign end_len   = (state == IDLE) ? 16'(beat_bytes) : len_acc;
  assign end_exp   = (state == IDLE) ? s_axis_tuser[15:0] : exp_len;
  assign frame_end = accept && s_axis_tlast;

  // Frame-end results are registered so counters update one cycle after the tlast beat is accepted
  logic        evt_vld, evt_runt, evt_giant, evt_err;
  logic [15:0] evt_len;

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state     <= IDLE;
      frame_len <= '0;
      exp_len   <= '0;
      evt_vld   <= 1'b0;
      evt_runt  <= 1'b0;
      evt_giant <= 1'b0;
      evt_err   <= 1'b0;
      evt_len   <= '0;
    end else begin
      if (accept) begin
        if (s_axis_tlast) begin
          state <= IDLE;
        end else if (state == IDLE) begin
          state     <= IN_FRAME;
          exp_len   <= s_axis_tuser[15:0];
          frame_len <= 16'(beat_bytes);
        end else begin
          frame_len <= len_acc;
        end
      end
      evt_vld   <= frame_end;
      evt_len   <= frame_end ? end_len : 16'd0;
      evt_runt  <= frame_end && (end_len < MIN_LEN);
      evt_giant <= frame_end && (end_len > MAX_LEN);
      evt_err   <= frame_end && (end_len != end_exp);
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    return (en && !(&cnt)) ? cnt + 32'd1 : cnt;
  endfunction

  logic [31:0]                 pkts_cnt, runts_cnt, giants_cnt, err_cnt, drops_cnt;
  logic [C_BYTE_CNT_WIDTH-1:0] bytes_cnt;
  logic [C_BYTE_CNT_WIDTH:0]   bytes_sum;
  logic                        link_q, link_drop, snap_q;

  assign bytes_sum = {1'b0, bytes_cnt} + (C_BYTE_CNT_WIDTH+1)'(evt_len);
  assign link_drop = link_q && !link_up;

  // On a snapshot the stat regs take the pre-increment value and the live counters keep only this cycle's event
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      pkts_cnt        <= '0;
      bytes_cnt       <= '0;
      runts_cnt       <= '0;
      giants_cnt      <= '0;
      err_cnt         <= '0;
      drops_cnt       <= '0;
      stat_pkts       <= '0;
      stat_bytes      <= '0;
      stat_runts      <= '0;
      stat_giants     <= '0;
      stat_len_err    <= '0;
      stat_link_drops <= '0;
      link_q          <= 1'b0;
      snap_q          <= 1'b0;
      stat_valid      <= 1'b0;
    end else begin
      link_q     <= link_up;
      snap_q     <= stats_snapshot;
      stat_valid <= snap_q;
      if (stats_snapshot) begin
        stat_pkts       <= pkts_cnt;
        stat_bytes      <= bytes_cnt;
        stat_runts      <= runts_cnt;
        stat_giants     <= giants_cnt;
        stat_len_err    <= err_cnt;
        stat_link_drops <= drops_cnt;
        pkts_cnt        <= 32'(evt_vld);
        bytes_cnt       <= C_BYTE_CNT_WIDTH'(evt_len);
        runts_cnt       <= 32'(evt_runt);
        giants_cnt      <= 32'(evt_giant);
        err_cnt         <= 32'(evt_err);
        drops_cnt       <= 32'(link_drop);
      end else begin
        pkts_cnt   <= sat_inc(pkts_cnt, evt_vld);
        bytes_cnt  <= bytes_sum[C_BYTE_CNT_WIDTH] ? '1 : bytes_sum[C_BYTE_CNT_WIDTH-1:0];
        runts_cnt  <= sat_inc(runts_cnt, evt_runt);
        giants_cnt <= sat_inc(giants_cnt, evt_giant);
        err_cnt    <= sat_inc(err_cnt, evt_err);
        drops_cnt  <= sat_inc(drops_cnt, link_drop);
      end
    end
  end

endmodule

// File: tb/tb_nf_10g_rx_port_stats.sv
// Directed bench for nf_10g_rx_port_stats: datapath scoreboard plus hand-computed counter values.
module tb_nf_10g_rx_port_stats;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          link_up = 1'b1;
  logic          stats_snapshot = 1'b0;
  logic [31:0]   stat_pkts, stat_runts, stat_giants, stat_len_err, stat_link_drops;
  logic [47:0]   stat_bytes;
  logic          stat_valid;

  always #5 clk = ~clk;

  nf_10g_rx_port_stats dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .link_up(link_up), .stats_snapshot(stats_snapshot),
    .stat_pkts(stat_pkts), .stat_bytes(stat_bytes), .stat_runts(stat_runts),
    .stat_giants(stat_giants), .stat_len_err(stat_len_err), .stat_link_drops(stat_link_drops),
    .stat_valid(stat_valid)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t out_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int comb_err = 0;

  // Output monitor: picks m_axis_tready, then records the handshake that the next rising edge will perform
  always @(negedge clk) begin
    logic  r0;
    beat_t b;
    cyc++;
    r0 = s_axis_tready;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
    #1;
    if (s_axis_tready !== r0) comb_err++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      b.data = m_axis_tdata; b.keep = m_axis_tkeep; b.user = m_axis_tuser;
      b.last = m_axis_tlast; b.cyc = cyc;
      out_q.push_back(b);
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [UW-1:0] u,
                            input logic l, input logic snap);
    beat_t b;
    logic  rdy;
    int    n;
    @(negedge clk);
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    stats_snapshot = snap && s_axis_tready;
    n = 0;
    forever begin
      rdy = s_axis_tready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout got=no_accept expected=accept_within_200");
        break;
      end
      @(negedge clk);
      stats_snapshot = 1'b0;
    end
    if (rdy) begin
      b.data = d; b.keep = k; b.user = u; b.last = l; b.cyc = cyc;
      exp_q.push_back(b);
    end
  endtask

  task automatic send_frame(input int len, input int ulen, input bit snap_last);
    int            rem, nb;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic [32:0]   m;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[15:0]  = ulen[15:0];
    u[23:16] = 8'($urandom);
    rem = len;
    while (rem > 0) begin
      nb = (rem > 32) ? 32 : rem;
      m = (33'd1 << nb) - 33'd1;
      k = m[31:0];
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      rem -= nb;
      drive_beat(d, k, u, rem == 0, snap_last && rem == 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      stats_snapshot = 1'b0;
    end
  endtask

  task automatic do_snapshot();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    stats_snapshot = 1'b1;
    @(negedge clk);
    stats_snapshot = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (out_q.size() < exp_q.size() && n < 5000) begin
      @(negedge clk); #2;
      n++;
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b expected=0", s_axis_tready); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b expected=0", m_axis_tvalid); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rel_tready got=%b expected=1", s_axis_tready); end
    total++; if (stat_pkts !== 0 || stat_bytes !== 0 || stat_valid !== 1'b0) begin
      bad++; $display("FAIL rst_stats got pkts=%0d bytes=%0d valid=%b expected 0/0/0", stat_pkts, stat_bytes, stat_valid);
    end
    idle(2);
    do_snapshot();
    total++; if ({stat_pkts, stat_bytes, stat_runts, stat_giants, stat_len_err, stat_link_drops} !== '0) begin
      bad++; $display("FAIL idle_snap got pkts=%0d bytes=%0d drops=%0d expected all zero", stat_pkts, stat_bytes, stat_link_drops);
    end
    total++; if (stat_valid !== 1'b0) begin bad++; $display("FAIL stat_valid_early got=%b expected=0", stat_valid); end
    @(negedge clk);
    total++; if (stat_valid !== 1'b1) begin bad++; $display("FAIL stat_valid_pulse got=%b expected=1", stat_valid); end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (stat_valid) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL stat_valid_extra got=%0d expected=0", pulses); end
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0;
    exp_q.delete(); out_q.delete();
    repeat (3) send_frame(64, 64, 0);
    idle(3);
    wait_drain();
    total++; if (out_q.size() != 6) begin bad++; $display("FAIL b2b_beats got=%0d expected=6", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      total++;
      if (out_q[i].data !== exp_q[i].data || out_q[i].keep !== exp_q[i].keep || out_q[i].user !== exp_q[i].user ||
          out_q[i].last !== exp_q[i].last || out_q[i].cyc != exp_q[i].cyc + 1) begin
        bad++; $display("FAIL b2b_beat%0d got cyc=%0d last=%b expected cyc=%0d last=%b",
                        i, out_q[i].cyc, out_q[i].last, exp_q[i].cyc + 1, exp_q[i].last);
      end
    end
    do_snapshot();
    total++; if (stat_pkts !== 32'd3) begin bad++; $display("FAIL b2b_pkts got=%0d expected=3", stat_pkts); end
    total++; if (stat_bytes !== 48'd192) begin bad++; $display("FAIL b2b_bytes got=%0d expected=192", stat_bytes); end
    total++; if (stat_runts !== 0 || stat_len_err !== 0 || stat_giants !== 0) begin
      bad++; $display("FAIL b2b_errs got runts=%0d giants=%0d len_err=%0d expected 0", stat_runts, stat_giants, stat_len_err);
    end
  endtask

  task automatic test_frame_checks();
    rdy_mode = 0;
    send_frame(42, 42, 0);
    send_frame(1518, 1518, 0);
    send_frame(96, 100, 0);
    idle(3);
    do_snapshot();
    total++; if (stat_runts !== 32'd1) begin bad++; $display("FAIL fc_runts got=%0d expected=1", stat_runts); end
    total++; if (stat_giants !== 32'd1) begin bad++; $display("FAIL fc_giants got=%0d expected=1", stat_giants); end
    total++; if (stat_len_err !== 32'd1) begin bad++; $display("FAIL fc_len_err got=%0d expected=1", stat_len_err); end
    total++; if (stat_pkts !== 32'd3) begin bad++; $display("FAIL fc_pkts got=%0d expected=3", stat_pkts); end
    total++; if (stat_bytes !== 48'd1656) begin bad++; $display("FAIL fc_bytes got=%0d expected=1656", stat_bytes); end
  endtask

  task automatic test_random_backpressure();
    int  len, runts;
    longint bytes;
    bit  ok;
    exp_q.delete(); out_q.delete();
    comb_err = 0; runts = 0; bytes = 0;
    rdy_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 200);
      bytes += len;
      if (len < 60) runts++;
      send_frame(len, len, 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    wait_drain();
    rdy_mode = 0;
    total++; if (out_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_beats got=%0d expected=%0d", out_q.size(), exp_q.size()); end
    ok = 1'b1;
    for (int i = 0; i < exp_q.size() && i < out_q.size() && ok; i++) begin
      total++;
      if (out_q[i].data !== exp_q[i].data || out_q[i].keep !== exp_q[i].keep ||
          out_q[i].user !== exp_q[i].user || out_q[i].last !== exp_q[i].last) begin
        bad++; ok = 1'b0;
        $display("FAIL rnd_beat%0d got keep=%h last=%b expected keep=%h last=%b",
                 i, out_q[i].keep, out_q[i].last, exp_q[i].keep, exp_q[i].last);
      end
    end
    total++; if (comb_err != 0) begin bad++; $display("FAIL rnd_tready_comb got=%0d expected=0", comb_err); end
    idle(3);
    do_snapshot();
    total++; if (stat_pkts !== 32'd1000) begin bad++; $display("FAIL rnd_pkts got=%0d expected=1000", stat_pkts); end
    total++; if (stat_bytes !== 48'(bytes)) begin bad++; $display("FAIL rnd_bytes got=%0d expected=%0d", stat_bytes, bytes); end
    total++; if (stat_runts !== 32'(runts)) begin bad++; $display("FAIL rnd_runts got=%0d expected=%0d", stat_runts, runts); end
    total++; if (stat_giants !== 0 || stat_len_err !== 0) begin
      bad++; $display("FAIL rnd_errs got giants=%0d len_err=%0d expected 0", stat_giants, stat_len_err);
    end
  endtask

  task automatic test_snapshot_coincident();
    rdy_mode = 0;
    idle(2);
    send_frame(100, 100, 1);
    idle(1);
    total++; if (stat_pkts !== 32'd0 || stat_bytes !== 48'd0) begin
      bad++; $display("FAIL coin_snap got pkts=%0d bytes=%0d expected 0/0", stat_pkts, stat_bytes);
    end
    idle(3);
    do_snapshot();
    total++; if (stat_pkts !== 32'd1) begin bad++; $display("FAIL coin_next_pkts got=%0d expected=1", stat_pkts); end
    total++; if (stat_bytes !== 48'd100) begin bad++; $display("FAIL coin_next_bytes got=%0d expected=100", stat_bytes); end
  endtask

  task automatic test_link_drops();
    idle(2);
    link_up = 1'b0; idle(2);
    link_up = 1'b1; idle(2);
    link_up = 1'b0; idle(2);
    link_up = 1'b1; idle(3);
    do_snapshot();
    total++; if (stat_link_drops !== 32'd2) begin bad++; $display("FAIL link_drops got=%0d expected=2", stat_link_drops); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] d;
    rdy_mode = 0;
    send_frame(64, 64, 0);
    idle(3);
    do_snapshot();
    total++; if (stat_pkts !== 32'd1) begin bad++; $display("FAIL rmf_pre_pkts got=%0d expected=1", stat_pkts); end
    send_frame(64, 64, 0);
    d = {8{$urandom}};
    drive_beat(d, '1, 128'd96, 1'b0, 1'b0);
    drive_beat(d, '1, 128'd96, 1'b0, 1'b0);
    @(negedge clk);
    s_axis_tlast = 1'b1;
    rst_n = 1'b0;
    link_up = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      bad++; $display("FAIL rmf_dp got mvalid=%b tready=%b expected 0/0", m_axis_tvalid, s_axis_tready);
    end
    total++; if (stat_pkts !== 32'd0 || stat_valid !== 1'b0) begin
      bad++; $display("FAIL rmf_stats got pkts=%0d valid=%b expected 0/0", stat_pkts, stat_valid);
    end
    s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
    idle(3);
    link_up = 1'b1;
    idle(1);
    exp_q.delete(); out_q.delete();
    send_frame(64, 64, 0);
    idle(3);
    wait_drain();
    total++; if (out_q.size() != 2 || exp_q.size() != 2) begin
      bad++; $display("FAIL rmf_beats got=%0d expected=2", out_q.size());
    end else begin
      total++; if (out_q[0].data !== exp_q[0].data || out_q[1].data !== exp_q[1].data || out_q[1].last !== 1'b1) begin
        bad++; $display("FAIL rmf_data got last=%b expected last=1 with matching data", out_q[1].last);
      end
    end
    do_snapshot();
    total++; if (stat_pkts !== 32'd1 || stat_bytes !== 48'd64) begin
      bad++; $display("FAIL rmf_post got pkts=%0d bytes=%0d expected 1/64", stat_pkts, stat_bytes);
    end
    total++; if (stat_link_drops !== 32'd0 || stat_len_err !== 32'd0) begin
      bad++; $display("FAIL rmf_drops got drops=%0d len_err=%0d expected 0/0", stat_link_drops, stat_len_err);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_frame_checks();
    test_random_backpressure();
    test_snapshot_coincident();
    test_link_drops();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
